// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencing, next-PC selection, traps and misalign checks.
// Optional compressed-instruction support is enabled with the PC_UNIT_RVC_EN macro.
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int unsigned     BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
`ifdef PC_UNIT_RVC_EN
  input  logic            is_compressed,
`endif
  output logic [XLEN-1:0] instruction_addr,
  output logic            pc_valid,
  output logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] epc,
  output logic            misalign_fault
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  localparam logic [2:0] SelBranch = 3'd1;
  localparam logic [2:0] SelJal    = 3'd2;
  localparam logic [2:0] SelJalr   = 3'd3;
  localparam logic [2:0] SelMret   = 3'd4;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            fault_q;
  logic [31:0]     boot_cnt_q;

  logic [XLEN-1:0] inc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] trap_target;
  logic            target_check;
  logic            misaligned;
  logic            boot_done;

  always_comb begin
    inc = XLEN'(4);
`ifdef PC_UNIT_RVC_EN
    if (is_compressed) inc = XLEN'(2);
`endif
    link_addr    = pc_q + inc;
    trap_target  = trap_vec & ~XLEN'(3);
    target       = link_addr;
    target_check = 1'b0;
    case (pc_sel)
      SelBranch: begin
        if (branch_taken) begin
          target       = pc_q + imm;
          target_check = 1'b1;
        end
      end
      SelJal: begin
        target       = pc_q + imm;
        target_check = 1'b1;
      end
      SelJalr: begin
        target       = (rs1_val + imm) & ~XLEN'(1);
        target_check = 1'b1;
      end
      SelMret: begin
        target       = epc_q;
        target_check = 1'b1;
      end
      default: ;
    endcase
`ifdef PC_UNIT_RVC_EN
    misaligned = target_check & target[0];
`else
    misaligned = target_check & (target[1:0] != 2'b00);
`endif
  end

  // BOOT_DELAY of 0 or 1 both leave BOOT after a single cycle.
  assign boot_done = (BOOT_DELAY <= 32'd1) || (boot_cnt_q == 32'(BOOT_DELAY - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_ADDR;
      epc_q      <= '0;
      fault_q    <= 1'b0;
      boot_cnt_q <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        StBoot: begin
          pc_q       <= RESET_ADDR;
          boot_cnt_q <= boot_cnt_q + 32'd1;
          if (boot_done) state_q <= StRun;
        end
        StRun: begin
          if (trap_req) begin
            epc_q <= pc_q;
            pc_q  <= trap_target;
          end else if (halt_req) begin
            state_q <= StHalt;
          end else if (!stall) begin
            if (misaligned) begin
              // A bad target is never fetched; it is redirected like a trap.
              epc_q   <= pc_q;
              pc_q    <= trap_target;
              fault_q <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end
        end
        StHalt: begin
          if (resume && !halt_req) state_q <= StRun;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign instruction_addr = pc_q;
  assign epc              = epc_q;
  assign misalign_fault   = fault_q;
  assign pc_valid         = (state_q == StRun);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected outputs are queued per step and checked after the edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        halt_req;
  logic        resume;
`ifdef PC_UNIT_RVC_EN
  logic        is_compressed;
`endif
  logic [31:0] instruction_addr;
  logic        pc_valid;
  logic [31:0] link_addr;
  logic [31:0] epc;
  logic        misalign_fault;

  pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .pc_sel           (pc_sel),
    .branch_taken     (branch_taken),
    .imm              (imm),
    .rs1_val          (rs1_val),
    .trap_req         (trap_req),
    .trap_vec         (trap_vec),
    .halt_req         (halt_req),
    .resume           (resume),
`ifdef PC_UNIT_RVC_EN
    .is_compressed    (is_compressed),
`endif
    .instruction_addr (instruction_addr),
    .pc_valid         (pc_valid),
    .link_addr        (link_addr),
    .epc              (epc),
    .misalign_fault   (misalign_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        fault;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Queue the expectation, let one edge pass, then compare what the DUT produced.
  task automatic step(input string tag, input logic [31:0] pc, input logic v,
                      input logic [31:0] e, input logic f);
    exp_t x;
    string t;
    x.pc = pc; x.valid = v; x.epc = e; x.fault = f;
    sb_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".pc"}, instruction_addr, x.pc);
    check({t, ".valid"}, {31'b0, pc_valid}, {31'b0, x.valid});
    check({t, ".epc"}, epc, x.epc);
    check({t, ".fault"}, {31'b0, misalign_fault}, {31'b0, x.fault});
    check({t, ".link"}, link_addr, x.pc + 32'd4);
  endtask

  task automatic idle();
    stall = 1'b0; pc_sel = 3'd0; branch_taken = 1'b0; imm = '0; rs1_val = '0;
    trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  logic [31:0] e_epc;

  initial begin
    idle();
    trap_vec = 32'h0000_0300;
    reset    = 1'b0;
`ifdef PC_UNIT_RVC_EN
    is_compressed = 1'b0;
`endif
    // Reset and boot delay
    step("rst0", 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst1", 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    step("boot0", 32'h0, 1'b0, 32'h0, 1'b0);
    step("boot1", 32'h0, 1'b1, 32'h0, 1'b0);
    step("seq4", 32'h4, 1'b1, 32'h0, 1'b0);
    step("seq8", 32'h8, 1'b1, 32'h0, 1'b0);
    step("seqC", 32'hC, 1'b1, 32'h0, 1'b0);
    step("seq10", 32'h10, 1'b1, 32'h0, 1'b0);
    // Branch / JALR
    pc_sel = 3'd1; imm = 32'h8; branch_taken = 1'b1;
    step("br_taken", 32'h18, 1'b1, 32'h0, 1'b0);
    pc_sel = 3'd3; rs1_val = 32'h10; imm = 32'h0;
    step("jalr_back", 32'h10, 1'b1, 32'h0, 1'b0);
    pc_sel = 3'd1; imm = 32'h8; branch_taken = 1'b0;
    step("br_not", 32'h14, 1'b1, 32'h0, 1'b0);
    pc_sel = 3'd3; rs1_val = 32'h101; imm = 32'h0;
    step("jalr_lsb", 32'h100, 1'b1, 32'h0, 1'b0);
    rs1_val = 32'h1F; imm = 32'h1;
    step("jalr_sum", 32'h20, 1'b1, 32'h0, 1'b0);
    // Trap beats stall, then MRET
    idle(); trap_req = 1'b1; stall = 1'b1; trap_vec = 32'h203;
    step("trap", 32'h200, 1'b1, 32'h20, 1'b0);
    idle(); pc_sel = 3'd4;
    step("mret", 32'h20, 1'b1, 32'h20, 1'b0);
    idle(); stall = 1'b1; pc_sel = 3'd2; imm = 32'h20;
    step("stall", 32'h20, 1'b1, 32'h20, 1'b0);
    stall = 1'b0;
    step("jal", 32'h40, 1'b1, 32'h20, 1'b0);
    // Misaligned JAL target
    trap_vec = 32'h301; imm = 32'h6;
`ifdef PC_UNIT_RVC_EN
    e_epc = 32'h20;
    step("jal6", 32'h46, 1'b1, e_epc, 1'b0);
    idle();
    step("after6", 32'h4A, 1'b1, e_epc, 1'b0);
`else
    e_epc = 32'h40;
    step("jal6", 32'h300, 1'b1, e_epc, 1'b1);
    idle();
    step("after6", 32'h304, 1'b1, e_epc, 1'b0);
`endif
    pc_sel = 3'd3; rs1_val = 32'h80; imm = 32'h0;
    step("jalr80", 32'h80, 1'b1, e_epc, 1'b0);
    // A misaligned offset on an untaken branch is not a fault
    pc_sel = 3'd1; imm = 32'h2; branch_taken = 1'b0;
    step("br_not_mis", 32'h84, 1'b1, e_epc, 1'b0);
    // Halt / resume
    idle(); halt_req = 1'b1;
    step("halt", 32'h84, 1'b0, e_epc, 1'b0);
    idle(); trap_req = 1'b1; pc_sel = 3'd2; imm = 32'h100;
    step("halt_frozen", 32'h84, 1'b0, e_epc, 1'b0);
    idle(); halt_req = 1'b1; resume = 1'b1;
    step("halt_both", 32'h84, 1'b0, e_epc, 1'b0);
    idle(); resume = 1'b1;
    step("resume", 32'h84, 1'b1, e_epc, 1'b0);
    idle();
    step("resume_seq", 32'h88, 1'b1, e_epc, 1'b0);
    // Wrap-around and reset mid-stream
    pc_sel = 3'd3; rs1_val = 32'hFFFF_FFFC; imm = 32'h0;
    step("top", 32'hFFFF_FFFC, 1'b1, e_epc, 1'b0);
    idle();
    step("wrap", 32'h0, 1'b1, e_epc, 1'b0);
    step("wrap_seq", 32'h4, 1'b1, e_epc, 1'b0);
    stall = 1'b1; reset = 1'b0;
    step("rst_mid", 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1; stall = 1'b0;
    step("reboot0", 32'h0, 1'b0, 32'h0, 1'b0);
    step("reboot1", 32'h0, 1'b1, 32'h0, 1'b0);
    step("reboot_seq", 32'h4, 1'b1, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
